// File: rtl/pattern_count_engine_pkg.sv
// pattern_count_engine_pkg
//   Shared definitions for the pattern-count engine:
//   - state_t : engine FSM states (also exported on the debug port)
//   - DEF_*   : default message length, pattern address and result address
//   - pat_t   : 5-bit search pattern
package pattern_count_engine_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PAT  = 3'd1,
    SCAN = 3'd2,
    WR0  = 3'd3,
    WR1  = 3'd4,
    WR2  = 3'd5,
    DONE = 3'd6
  } state_t;

  localparam int DEF_MSG_BYTES = 32;
  localparam int DEF_PAT_ADDR  = 32;
  localparam int DEF_RES_ADDR  = 33;

  typedef logic [4:0] pat_t;

endpackage

// File: rtl/pattern_count_engine_window_match.sv
// window_match
//   Purely combinational matcher for one message byte.
//   win_i holds {prev4, byte}: the low nibble of the previous byte followed by
//   the current byte, MSB first. Stream position p (0 = bit 11) covers
//   win_i[11-p -: 5]. Positions 0..3 straddle the byte boundary; positions
//   4..7 are the in-byte windows b[7:3], b[6:2], b[5:1], b[4:0].
// Ports:
//   win_i     - {prev4, byte}
//   pat_i     - 5-bit pattern
//   first_i   - current byte is message byte 0 (no previous nibble exists)
//   inb_cnt_o - in-byte matches, 0..4
//   inb_any_o - at least one in-byte match
//   str_cnt_o - stream matches ending inside this byte, 0..8
module window_match
  import pattern_count_engine_pkg::*;
(
  input  logic [11:0] win_i,
  input  pat_t        pat_i,
  input  logic        first_i,
  output logic [2:0]  inb_cnt_o,
  output logic        inb_any_o,
  output logic [3:0]  str_cnt_o
);

  logic [2:0] inb_cnt;
  logic [2:0] cross_cnt;

  always_comb begin
    inb_cnt   = '0;
    cross_cnt = '0;
    for (int p = 0; p < 8; p++) begin
      if (win_i[11-p -: 5] == pat_i) begin
        if (p < 4) cross_cnt = cross_cnt + 3'd1;
        else       inb_cnt   = inb_cnt + 3'd1;
      end
    end
  end

  assign inb_cnt_o = inb_cnt;
  assign inb_any_o = |inb_cnt;
  // Byte 0 has no predecessor, so its crossing windows do not exist.
  assign str_cnt_o = first_i ? {1'b0, inb_cnt} : ({1'b0, inb_cnt} + {1'b0, cross_cnt});

endmodule

// File: rtl/pattern_count_engine.sv
// pattern_count_engine
//   Reads a 5-bit pattern from PAT_ADDR, scans MSG_BYTES message bytes from
//   address 0 and writes ctb / cto / cts to RES_ADDR, RES_ADDR+1, RES_ADDR+2.
// Ports:
//   Clk, Reset (async, active low)
//   Start     - run request, sampled only in IDLE or DONE
//   Ack       - level, high while in DONE
//   MemAddr   - registered data-memory address
//   MemRdData - combinational read data for MemAddr
//   MemWrEn   - registered write strobe, memory writes on the rising edge
//   MemWrData - registered write data
//   DbgState  - current FSM state
// Handshake: a run begins at the edge that samples Start=1 while in IDLE or
// DONE; Ack is then low for the whole run and goes high after the third result
// write, staying high until the next accepted Start. Start is ignored while a
// run is in progress.
module pattern_count_engine
  import pattern_count_engine_pkg::*;
#(
  parameter int MSG_BYTES = DEF_MSG_BYTES,
  parameter int PAT_ADDR  = DEF_PAT_ADDR,
  parameter int RES_ADDR  = DEF_RES_ADDR
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  output logic       Ack,
  output logic [7:0] MemAddr,
  input  logic [7:0] MemRdData,
  output logic       MemWrEn,
  output logic [7:0] MemWrData,
  output state_t     DbgState
);

  state_t     state_q;
  pat_t       pat_q;
  logic [7:0] idx_q;
  logic [3:0] prev4_q;
  logic [7:0] ctb_q, cto_q, cts_q;
  logic [7:0] ctb_d, cto_d, cts_d;
  logic       ack_q, wen_q;
  logic [7:0] addr_q, wdata_q;

  logic [2:0] inb_cnt;
  logic       inb_any;
  logic [3:0] str_cnt;
  logic       last_byte;

  window_match u_match (
    .win_i     ({prev4_q, MemRdData}),
    .pat_i     (pat_q),
    .first_i   (idx_q == 8'd0),
    .inb_cnt_o (inb_cnt),
    .inb_any_o (inb_any),
    .str_cnt_o (str_cnt)
  );

  // Next counter values include the byte presented this cycle, so the final
  // SCAN edge can load ctb_d straight into the first write.
  assign ctb_d     = ctb_q + {5'd0, inb_cnt};
  assign cto_d     = cto_q + {7'd0, inb_any};
  assign cts_d     = cts_q + {4'd0, str_cnt};
  assign last_byte = (idx_q == 8'(MSG_BYTES - 1));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      pat_q   <= '0;
      idx_q   <= '0;
      prev4_q <= '0;
      ctb_q   <= '0;
      cto_q   <= '0;
      cts_q   <= '0;
      ack_q   <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      wen_q <= 1'b0;
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Start) begin
            state_q <= PAT;
            addr_q  <= 8'(PAT_ADDR);
          end
        end
        PAT: begin
          pat_q   <= MemRdData[4:0];
          idx_q   <= '0;
          prev4_q <= '0;
          ctb_q   <= '0;
          cto_q   <= '0;
          cts_q   <= '0;
          addr_q  <= '0;
          state_q <= SCAN;
        end
        SCAN: begin
          ctb_q   <= ctb_d;
          cto_q   <= cto_d;
          cts_q   <= cts_d;
          prev4_q <= MemRdData[3:0];
          idx_q   <= idx_q + 8'd1;
          if (last_byte) begin
            state_q <= WR0;
            addr_q  <= 8'(RES_ADDR);
            wen_q   <= 1'b1;
            wdata_q <= ctb_d;
          end else begin
            addr_q  <= idx_q + 8'd1;
          end
        end
        WR0: begin
          state_q <= WR1;
          addr_q  <= 8'(RES_ADDR + 1);
          wen_q   <= 1'b1;
          wdata_q <= cto_q;
        end
        WR1: begin
          state_q <= WR2;
          addr_q  <= 8'(RES_ADDR + 2);
          wen_q   <= 1'b1;
          wdata_q <= cts_q;
        end
        WR2: begin
          state_q <= DONE;
          ack_q   <= 1'b1;
        end
        DONE: begin
          if (Start) begin
            state_q <= PAT;
            addr_q  <= 8'(PAT_ADDR);
          end else begin
            ack_q   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Ack       = ack_q;
  assign MemAddr   = addr_q;
  assign MemWrEn   = wen_q;
  assign MemWrData = wdata_q;
  assign DbgState  = state_q;

endmodule

// File: tb/tb_pattern_count_engine.sv
module tb_pattern_count_engine;
  import pattern_count_engine_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic       ack;
  logic [7:0] mem_addr, mem_wdata;
  logic       mem_we;
  state_t     dbg_state;

  logic [7:0] mem [256];
  logic [7:0] img [256];
  logic       tb_we = 1'b0;
  logic [7:0] tb_addr = '0;
  logic [7:0] tb_data = '0;

  pattern_count_engine dut (
    .Clk       (clk),
    .Reset     (rst_n),
    .Start     (start),
    .Ack       (ack),
    .MemAddr   (mem_addr),
    .MemRdData (mem[mem_addr]),
    .MemWrEn   (mem_we),
    .MemWrData (mem_wdata),
    .DbgState  (dbg_state)
  );

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else if (tb_we) mem[tb_addr] <= tb_data;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];  // {address, data} of each expected result write

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", {24'd0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("wr_addr", {24'd0, mem_addr}, {24'd0, e[15:8]});
        check("wr_data", {24'd0, mem_wdata}, {24'd0, e[7:0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Message: byte0=b0, byte1=b1, bytes 2..31=fill; pattern byte; results preset.
  task automatic load(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] fill,
                      input logic [7:0] pat);
    for (int i = 0; i < 36; i++) begin
      logic [7:0] v;
      if (i == 0) v = b0;
      else if (i == 1) v = b1;
      else if (i < 32) v = fill;
      else if (i == 32) v = pat;
      else v = 8'hA0 + 8'(i - 32);
      img[i] = v;
      @(negedge clk);
      tb_we = 1'b1; tb_addr = 8'(i); tb_data = v;
    end
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // Issue Start and time Ack; mid_start pulses Start again during SCAN.
  task automatic run(input string name, input logic [7:0] ctb, input logic [7:0] cto,
                     input logic [7:0] cts, input bit mid_start);
    logic ack_before;
    int cyc;
    exp_q.push_back({8'd33, ctb});
    exp_q.push_back({8'd34, cto});
    exp_q.push_back({8'd35, cts});
    ack_before = ack;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);  // E0
    #1 start = 1'b0;
    if (ack_before) check({name, "_ack_drop"}, {31'd0, ack}, 32'd0);
    cyc = 0;
    while (cyc < 40) begin
      @(posedge clk);
      #1 cyc++;
      if (mid_start && cyc == 9) start = 1'b1;
      if (mid_start && cyc == 10) start = 1'b0;
      if (ack) break;
    end
    check({name, "_ack_cycle"}, cyc, 32'd36);
    check({name, "_queue_drained"}, exp_q.size(), 32'd0);
    check({name, "_mem33"}, {24'd0, mem[33]}, {24'd0, ctb});
    check({name, "_mem34"}, {24'd0, mem[34]}, {24'd0, cto});
    check({name, "_mem35"}, {24'd0, mem[35]}, {24'd0, cts});
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_wen", {31'd0, mem_we}, 32'd0);
    check("rst_addr", {24'd0, mem_addr}, 32'd0);
    check("rst_wdata", {24'd0, mem_wdata}, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    load(8'h00, 8'h00, 8'h00, 8'h00);
    run("zeros", 8'd128, 8'd32, 8'd252, 1'b0);

    load(8'h55, 8'h55, 8'h55, 8'h15);
    run("alt55", 8'd64, 8'd32, 8'd126, 1'b0);

    load(8'h01, 8'hC0, 8'h00, 8'h07);
    run("crossing", 8'd0, 8'd0, 8'd1, 1'b0);

    load(8'h55, 8'h55, 8'h55, 8'hF5);
    run("pat_hi_ignored", 8'd64, 8'd32, 8'd126, 1'b0);
    for (int i = 0; i < 33; i++) check("msg_untouched", {24'd0, mem[i]}, {24'd0, img[i]});

    // Reset mid-run: no writes may happen, preset results survive.
    load(8'hFF, 8'hFF, 8'hFF, 8'h1F);
    begin
      bit ack_seen;
      ack_seen = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);  // E0
      #1 start = 1'b0;
      for (int c = 1; c <= 15; c++) begin
        @(posedge clk);
        #1 if (ack) ack_seen = 1'b1;
      end
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 if (ack) ack_seen = 1'b1;
      check("midrst_ack_seen", {31'd0, ack_seen}, 32'd0);
      check("midrst_state", 32'(dbg_state), 32'(IDLE));
      check("midrst_mem33", {24'd0, mem[33]}, 32'hA1);
      check("midrst_mem34", {24'd0, mem[34]}, 32'hA2);
      check("midrst_mem35", {24'd0, mem[35]}, 32'hA3);
      @(negedge clk);
      rst_n = 1'b1;
    end
    run("after_reset", 8'd128, 8'd32, 8'd252, 1'b0);

    // Start pulsed during SCAN is ignored; a second Start from DONE repeats the run.
    load(8'h55, 8'h55, 8'h55, 8'h15);
    run("mid_start", 8'd64, 8'd32, 8'd126, 1'b1);
    run("rerun", 8'd64, 8'd32, 8'd126, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pattern_count_engine.md
# pattern_count_engine

Hardware engine that runs the program-3 pattern-count workload without the CPU core. On Start it reads a 5-bit pattern from data-memory byte 32, scans the 32-byte message in bytes 0–31, and writes three counts back to bytes 33, 34 and 35. It sits between TopLevel's Start/Ack handshake and the data memory (DM1) port, and is the downstream consumer of the message and pattern loaded into DM1.

## Interface
- MSG_BYTES, default 32: number of message bytes scanned starting at address 0.
- PAT_ADDR, default 32: address of the pattern byte.
- RES_ADDR, default 33: first result address; results go to RES_ADDR, RES_ADDR+1 and RES_ADDR+2.
- Clk, input, 1 bit: single clock; all state changes on the rising edge.
- Reset, input, 1 bit: **asynchronous, active-low** reset.
- Start, input, 1 bit: run request, sampled in IDLE or DONE.
- Ack, output, 1 bit: high while in DONE (level).
- MemAddr, output, 8 bits: data-memory address.
- MemRdData, input, 8 bits: combinational read data for MemAddr, valid in the same cycle.
- MemWrEn, output, 1 bit: write strobe; memory writes at the rising edge.
- MemWrData, output, 8 bits: write data.

## Operation
- Pattern is `MemRdData[4:0]` of the byte at PAT_ADDR; bits [7:5] are ignored.
- Message stream: byte 0 comes first, and each byte is taken MSB first. This gives a 256-bit string.
- For each byte b, the four in-byte windows are b[4:0], b[5:1], b[6:2] and b[7:3].
- Counts:
  - ctb: number of in-byte windows equal to the pattern, max 128.
  - cto: number of bytes with at least one matching in-byte window, max 32.
  - cts: number of matching 5-bit windows at stream start positions 0..251, including windows that cross byte boundaries, max 252.
- cts is computed incrementally:
  - Keep prev4, the low 4 bits of the previous byte.
  - For byte 0, check its 4 in-byte windows.
  - For byte i>0, check the 8 windows of {prev4, b[7:0]} that end inside b: the 4 crossing windows plus the 4 in-byte windows.
- All counters are 8 bits. Maxima fit, so there is no saturation logic.
- FSM states:
  - IDLE → PAT on Start.
  - PAT: MemAddr=PAT_ADDR. Latch the pattern, clear ctb/cto/cts/prev4 and the index → SCAN.
  - SCAN: MemAddr=index. Accumulate, update prev4 and increment the index. After index MSG_BYTES-1 → WR0.
  - WR0, WR1, WR2: MemWrEn=1. MemAddr=RES_ADDR+0/1/2. MemWrData=ctb / cto / cts.
  - WR2 → DONE.
  - DONE: Ack=1. Start → PAT (new run; Ack drops).
- Start is ignored in PAT, SCAN and WR*.
- The engine never writes addresses 0..RES_ADDR-1.

## Timing
- Call the edge that samples Start=1 E0.
- PAT occupies the cycle after E0. SCAN of byte k completes at edge E(k+2).
- Result writes occur at E34, E35 and E36.
- Ack rises after E36, i.e. 36 cycles after E0 with default parameters.
- Reset values: state=IDLE, Ack=0, MemWrEn=0, MemAddr=0, MemWrData=0, all counters and prev4 = 0.
- Reset asserted mid-run: return to IDLE immediately, with no further or partial writes (MemWrEn low asynchronously). Results already written remain in memory.
- Start held high continuously from DONE: a run restarts every 37 cycles, and Ack is high for exactly one cycle per run.
- MemWrEn is never high outside WR0–WR2.

## Structure
- A shared package holds:
  - the state enum (IDLE, PAT, SCAN, WR0, WR1, WR2, DONE);
  - the default address constants 32 and 33;
  - the 5-bit pattern type.
- One sub-module, `window_match`, is purely combinational. Inputs: 12-bit {prev4, byte}, the pattern, and a first-byte flag. Outputs: in-byte match count (0–4), any-in-byte flag, and stream match count (0–8).
- The top module holds the FSM, counters and memory mux.

## Test plan
- Bytes 0..31 = 0x00, pattern byte 0x00 → Core[33]=128, Core[34]=32, Core[35]=252; Ack at E0+36.
- Bytes = 0x55, pattern 0x15 → 64, 32, 126.
- Byte0=0x01, byte1=0xC0, rest 0x00, pattern 0x07 → 0, 0, 1 (crossing-only match).
- Pattern byte 0xF5 with 0x55 message → same as the 0x15 case (bits [7:5] ignored). Verify addresses 0..32 are unmodified after the run.
- Reset pulsed low at E0+15 → Ack stays 0, MemWrEn never asserts, and Core[33..35] keep their pre-run values. A following Start completes normally with correct counts.
- Start pulsed during SCAN is ignored (Ack still at E0+36). A second Start in DONE drops Ack after one edge and reproduces identical results.
